// File: rtl/gesture_stream_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : gesture_stream_tx_if
// Description : Pair-stream bundle from gesture_stream_tx to the similarity
//               scorer: pair valid, running index, live/library vectors and
//               the busy/done status.
// Revision    : 1.0 - initial release
// ============================================================================
interface gesture_stream_tx_if #(
  parameter int W     = 8,
  parameter int IDX_W = 9
);
  logic             o_valid;
  logic [IDX_W-1:0] o_index;
  logic [W-1:0]     o_vector_x;
  logic [W-1:0]     o_vector_y;
  logic [W-1:0]     o_lib_x;
  logic [W-1:0]     o_lib_y;
  logic             o_busy;
  logic             o_done;

  modport master (
    output o_valid, o_index, o_vector_x, o_vector_y,
    output o_lib_x, o_lib_y, o_busy, o_done
  );

  modport slave (
    input o_valid, o_index, o_vector_x, o_vector_y,
    input o_lib_x, o_lib_y, o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/gesture_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : gesture_stream_tx
// Description : Keeps a sliding window of the live motion-vector stream and,
//               on a start request, streams every (snapshot vector, library
//               vector) pair for all library gestures with a running index.
//               Library vectors come from a 1-cycle-latency synchronous ROM.
// Revision    : 1.0 - initial release
// ============================================================================
module gesture_stream_tx #(
  parameter int N_VEC  = 16,
  parameter int N_GEST = 26,
  parameter int W      = 8
) (
  input  wire logic                                 i_clk,
  input  wire logic                                 i_rst_n,
  input  wire logic                                 i_vec_valid,
  input  wire logic [W-1:0]                         i_vec_x,
  input  wire logic [W-1:0]                         i_vec_y,
  input  wire logic                                 i_clear,
  input  wire logic                                 i_start,
  output logic      [$clog2(N_VEC*N_GEST)-1:0]      o_lib_addr,
  input  wire logic [W-1:0]                         i_lib_x,
  input  wire logic [W-1:0]                         i_lib_y,
  gesture_stream_tx_if.master                       stream
);

  localparam int IDX_W = $clog2(N_VEC * N_GEST);
  localparam int PTR_W = $clog2(N_VEC);
  localparam logic [PTR_W:0]   c_full = (PTR_W + 1)'(N_VEC);
  localparam logic [IDX_W-1:0] c_last = IDX_W'(N_VEC * N_GEST - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FETCH  = 2'd1,
    S_STREAM = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [IDX_W-1:0] w_cnt_nxt;

  logic [W-1:0]     r_win_x  [N_VEC];
  logic [W-1:0]     r_win_y  [N_VEC];
  logic [W-1:0]     r_snap_x [N_VEC];
  logic [W-1:0]     r_snap_y [N_VEC];
  logic [PTR_W-1:0] r_wptr;
  logic [PTR_W:0]   r_fill;

  logic             w_accept;

  logic             r_valid;
  logic [IDX_W-1:0] r_index;
  logic [W-1:0]     r_vec_x;
  logic [W-1:0]     r_vec_y;
  logic [W-1:0]     r_lib_x;
  logic [W-1:0]     r_lib_y;
  logic             r_busy;
  logic             r_done;

  // A start only counts from IDLE with a completely filled window; the fill
  // count seen here is the pre-edge value, so a same-cycle write cannot help.
  assign w_accept = (r_state == S_IDLE) && i_start && (r_fill == c_full);

  // Live capture never stalls; a flush wins over a coincident write.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_fill <= '0;
      for (int k = 0; k < N_VEC; k++) begin
        r_win_x[k] <= '0;
        r_win_y[k] <= '0;
      end
    end else if (i_clear) begin
      r_wptr <= '0;
      r_fill <= '0;
    end else if (i_vec_valid) begin
      r_win_x[r_wptr] <= i_vec_x;
      r_win_y[r_wptr] <= i_vec_y;
      r_wptr          <= r_wptr + 1'b1;
      if (r_fill != c_full) begin
        r_fill <= r_fill + 1'b1;
      end
    end
  end

  // Freeze the window oldest-first on an accepted start; the write pointer
  // points at the oldest entry once the window is full.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < N_VEC; k++) begin
        r_snap_x[k] <= '0;
        r_snap_y[k] <= '0;
      end
    end else if (w_accept) begin
      for (int k = 0; k < N_VEC; k++) begin
        r_snap_x[k] <= r_win_x[r_wptr + PTR_W'(k)];
        r_snap_y[k] <= r_win_y[r_wptr + PTR_W'(k)];
      end
    end
  end

  // State and pair counter registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next-state: one FETCH cycle primes the ROM pipeline, then one pair per
  // cycle with no gaps, then a single DONE cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt = S_FETCH;
          w_cnt_nxt   = '0;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_STREAM;
      end
      S_STREAM: begin
        if (r_cnt == c_last) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // ROM address runs one ahead of the pair being captured so data arrives
  // exactly when that pair is registered; it holds at the last address.
  always_comb begin
    o_lib_addr = '0;
    if (r_state == S_STREAM) begin
      o_lib_addr = (r_cnt == c_last) ? c_last : (r_cnt + 1'b1);
    end
  end

  // Output stage: every stream output is registered one cycle behind the
  // state so the library data and the snapshot vector line up; idle cycles
  // force data and index to zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_index <= '0;
      r_vec_x <= '0;
      r_vec_y <= '0;
      r_lib_x <= '0;
      r_lib_y <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_valid <= (r_state == S_STREAM);
      r_done  <= (r_state == S_DONE);
      r_busy  <= (r_state != S_IDLE);
      if (r_state == S_STREAM) begin
        r_index <= r_cnt;
        r_vec_x <= r_snap_x[r_cnt[PTR_W-1:0]];
        r_vec_y <= r_snap_y[r_cnt[PTR_W-1:0]];
        r_lib_x <= i_lib_x;
        r_lib_y <= i_lib_y;
      end else begin
        r_index <= '0;
        r_vec_x <= '0;
        r_vec_y <= '0;
        r_lib_x <= '0;
        r_lib_y <= '0;
      end
    end
  end

  assign stream.o_valid    = r_valid;
  assign stream.o_index    = r_index;
  assign stream.o_vector_x = r_vec_x;
  assign stream.o_vector_y = r_vec_y;
  assign stream.o_lib_x    = r_lib_x;
  assign stream.o_lib_y    = r_lib_y;
  assign stream.o_busy     = r_busy;
  assign stream.o_done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_gesture_stream_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_gesture_stream_tx
// Description : Scoreboard bench for gesture_stream_tx. Stimulus pushes the
//               expected pair sequence and done cycle; a monitor pops and
//               compares whenever the DUT presents a pair or a done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gesture_stream_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vec_valid = 1'b0;
  logic [7:0] vec_x = 8'd0;
  logic [7:0] vec_y = 8'd0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic [8:0] lib_addr;
  logic [7:0] lib_x = 8'd0;
  logic [7:0] lib_y = 8'd0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int busy_run = 0;
  int busy_last = 0;

  typedef struct {
    int         cyc;
    logic [8:0] idx;
    logic [7:0] vx;
    logic [7:0] vy;
    logic [7:0] lx;
    logic [7:0] ly;
  } exp_t;

  exp_t       exp_q [$];
  int         done_q [$];
  logic [7:0] ex [16];

  gesture_stream_tx_if #(.W(8), .IDX_W(9)) s_if ();

  gesture_stream_tx #(.N_VEC(16), .N_GEST(26), .W(8)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_vec_valid (vec_valid),
    .i_vec_x     (vec_x),
    .i_vec_y     (vec_y),
    .i_clear     (clr),
    .i_start     (start),
    .o_lib_addr  (lib_addr),
    .i_lib_x     (lib_x),
    .i_lib_y     (lib_y),
    .stream      (s_if)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // ROM model: x = addr[7:0], y = 1, one cycle of read latency
  initial forever begin
    @(posedge clk);
    lib_x <= lib_addr[7:0];
    lib_y <= 8'd1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total = total + 1;
    if (act !== req) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    int   d;
    forever begin
      @(negedge clk);
      if (s_if.o_busy) busy_run = busy_run + 1;
      else begin
        if (busy_run != 0) busy_last = busy_run;
        busy_run = 0;
      end
      if (s_if.o_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", 32'(s_if.o_index), 32'h0000_ffff);
        end else begin
          e = exp_q.pop_front();
          chk("pair_cycle", cyc, e.cyc);
          chk("pair_index", 32'(s_if.o_index), 32'(e.idx));
          chk("vector_x", 32'(s_if.o_vector_x), 32'(e.vx));
          chk("vector_y", 32'(s_if.o_vector_y), 32'(e.vy));
          chk("lib_x", 32'(s_if.o_lib_x), 32'(e.lx));
          chk("lib_y", 32'(s_if.o_lib_y), 32'(e.ly));
        end
      end else begin
        chk("idle_zero", 32'({s_if.o_index, s_if.o_vector_x, s_if.o_vector_y} | 
                             {9'd0, s_if.o_lib_x, s_if.o_lib_y}), 32'd0);
      end
      if (s_if.o_done) begin
        if (done_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          d = done_q.pop_front();
          chk("done_cycle", cyc, d);
        end
      end
    end
  end

  task automatic put_vec(input logic [7:0] x);
    @(negedge clk);
    vec_valid = 1'b1;
    vec_x = x;
    vec_y = 8'd0 - x;
    @(posedge clk);
    #1 vec_valid = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(posedge clk);
    #1 clr = 1'b0;
  endtask

  task automatic pulse_start(input bit with_vec, input logic [7:0] x, output int s);
    @(negedge clk);
    start = 1'b1;
    if (with_vec) begin
      vec_valid = 1'b1;
      vec_x = x;
      vec_y = 8'd0 - x;
    end
    @(posedge clk);
    #1;
    s = cyc;
    start = 1'b0;
    vec_valid = 1'b0;
  endtask

  task automatic expect_stream(input int s);
    exp_t e;
    for (int n = 0; n < 416; n++) begin
      e.cyc = s + 2 + n;
      e.idx = 9'(n);
      e.vx  = ex[n % 16];
      e.vy  = 8'd0 - ex[n % 16];
      e.lx  = 8'(n);
      e.ly  = 8'd1;
      exp_q.push_back(e);
    end
    done_q.push_back(s + 418);
  endtask

  task automatic wait_end();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || done_q.size() != 0) && t < 1000) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("stream_outstanding", 32'(exp_q.size() + done_q.size()), 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    chk("busy_length", busy_last, 418);
  endtask

  initial begin
    int s;
    int s2;
    int t;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(s_if.o_valid), 32'd0);
    chk("rst_index", 32'(s_if.o_index), 32'd0);
    chk("rst_busy", 32'(s_if.o_busy), 32'd0);
    chk("rst_done", 32'(s_if.o_done), 32'd0);
    chk("rst_addr", 32'(lib_addr), 32'd0);
    chk("rst_vec_x", 32'(s_if.o_vector_x), 32'd0);
    chk("rst_lib_y", 32'(s_if.o_lib_y), 32'd0);
    rst_n = 1'b1;

    // fill and stream
    for (int k = 0; k < 16; k++) put_vec(8'(k));
    for (int k = 0; k < 16; k++) ex[k] = 8'(k);
    pulse_start(1'b0, 8'd0, s);
    expect_stream(s);
    wait_end();

    // wrap order: 20 writes -> oldest is 4
    do_clear();
    for (int k = 0; k < 20; k++) put_vec(8'(k));
    for (int k = 0; k < 16; k++) ex[k] = 8'(k + 4);
    pulse_start(1'b0, 8'd0, s);
    expect_stream(s);
    wait_end();

    // underfill: 15 vectors, start dropped
    do_clear();
    for (int k = 0; k < 15; k++) put_vec(8'(k));
    pulse_start(1'b0, 8'd0, s);
    repeat (5) @(negedge clk);
    chk("underfill_busy", 32'(s_if.o_busy), 32'd0);
    put_vec(8'd15);
    for (int k = 0; k < 16; k++) ex[k] = 8'(k);
    pulse_start(1'b0, 8'd0, s);
    expect_stream(s);
    wait_end();

    // coincident start + write: snapshot uses pre-write contents
    for (int k = 0; k < 16; k++) ex[k] = 8'(k);
    pulse_start(1'b1, 8'd99, s);
    expect_stream(s);
    wait_end();

    // next start sees 1..15, 99; capture and a start mid-stream
    for (int k = 0; k < 15; k++) ex[k] = 8'(k + 1);
    ex[15] = 8'd99;
    pulse_start(1'b0, 8'd0, s);
    expect_stream(s);
    repeat (40) @(negedge clk);
    for (int j = 0; j < 10; j++) put_vec(8'(200 + j));
    pulse_start(1'b0, 8'd0, s2);
    wait_end();

    // window updated after the stream
    for (int k = 0; k < 5; k++) ex[k] = 8'(11 + k);
    ex[5] = 8'd99;
    for (int k = 0; k < 10; k++) ex[6 + k] = 8'(200 + k);
    pulse_start(1'b0, 8'd0, s);
    expect_stream(s);
    wait_end();

    // clear after a full window: start ignored
    do_clear();
    pulse_start(1'b0, 8'd0, s);
    repeat (4) @(negedge clk);
    chk("clear_busy", 32'(s_if.o_busy), 32'd0);
    chk("clear_valid", 32'(s_if.o_valid), 32'd0);

    // reset mid-stream at index 200
    for (int k = 0; k < 16; k++) put_vec(8'(k + 30));
    for (int k = 0; k < 16; k++) ex[k] = 8'(k + 30);
    pulse_start(1'b0, 8'd0, s);
    expect_stream(s);
    t = 0;
    while (!(s_if.o_valid && s_if.o_index == 9'd200) && t < 600) begin
      @(negedge clk);
      t = t + 1;
    end
    chk("reach_index_200", 32'(s_if.o_index), 32'd200);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(s_if.o_valid), 32'd0);
    chk("arst_index", 32'(s_if.o_index), 32'd0);
    chk("arst_vec_x", 32'(s_if.o_vector_x), 32'd0);
    chk("arst_lib_x", 32'(s_if.o_lib_x), 32'd0);
    chk("arst_busy", 32'(s_if.o_busy), 32'd0);
    chk("arst_addr", 32'(lib_addr), 32'd0);
    exp_q.delete();
    done_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_busy", 32'(s_if.o_busy), 32'd0);
    chk("post_rst_done", 32'(s_if.o_done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gesture_stream_tx.md
Name: gesture_stream_tx

Overview:
- Producer feeding the gesture similarity scorer.
- Captures the live 60 fps motion-vector stream into a 16-entry sliding window.
- On a trigger, snapshots the window and streams 26 gestures x 16 vectors = 416 (live vector, library vector) pairs with a running index.
- Library vectors are fetched from an external synchronous ROM that has 1-cycle read latency.

Parameters:
- N_VEC, 16, vectors per gesture and window depth; power of two.
- N_GEST, 26, number of library gestures.
- W, 8, component width; two's complement.

Ports:
- i_clk, in, 1, clock.
- i_rst_n, in, 1, asynchronous active-low reset.
- i_vec_valid, in, 1, live vector strobe; one vector per strobe.
- i_vec_x, in, W, live vector x.
- i_vec_y, in, W, live vector y.
- i_clear, in, 1, synchronous window flush.
- i_start, in, 1, stream request, single-cycle pulse.
- o_lib_addr, out, 9, ROM address (gesture*16 + vector).
- i_lib_x, in, W, ROM data x; valid 1 cycle after address.
- i_lib_y, in, W, ROM data y.
- o_valid, out, 1, pair valid.
- o_index, out, 9, pair index, 0..415.
- o_vector_x, out, W, snapshot live x.
- o_vector_y, out, W, snapshot live y.
- o_lib_x, out, W, library x.
- o_lib_y, out, W, library y.
- o_busy, out, 1, high in every state except IDLE.
- o_done, out, 1, one-cycle pulse after the last pair.

Behaviour:
- Reset: async, active-low. Clears state to IDLE, window, write pointer, fill count, snapshot, and all outputs to 0.
- Window:
  - 16-entry circular buffer with a 4-bit write pointer that wraps 15->0.
  - Fill count saturates at 16.
  - Every i_vec_valid writes at the pointer and increments it, in all states. Capture never stalls.
- i_clear: zeroes the fill count and pointer next edge. Has priority over a same-cycle write. Ignored for the stream already in progress.
- Start acceptance: i_start is accepted only when state is IDLE and the fill count is 16 before this edge. Otherwise it is silently dropped.
- Snapshot on acceptance:
  - Copy window into snapshot oldest-first: snap[k] = win[(wptr + k) mod 16].
  - Uses pre-write contents when i_vec_valid coincides.
  - Snapshot stays frozen until the next accepted start.
- FSM:
  - IDLE -> FETCH on accepted start.
  - FETCH: o_lib_addr = 0. Lasts 1 cycle; -> STREAM.
  - STREAM: 416 consecutive cycles with o_valid = 1.
    - Cycle n: o_index = n; o_vector = snap[n[3:0]]; o_lib = ROM data for address n.
    - o_lib_addr = n+1 while n < 415, else held.
    - After n = 415 -> DONE.
  - DONE: o_done = 1 and o_valid = 0 for 1 cycle; -> IDLE.
- Latency and throughput:
  - First o_valid is exactly 2 cycles after the edge that samples an accepted i_start.
  - Total busy time is 418 cycles.
  - No gaps and no backpressure.
- Output data:
  - o_vector and o_lib are registered-equivalent, stable for the whole cycle with o_valid.
  - When o_valid = 0: data outputs hold 0 and o_index holds 0.
- Gesture boundary: o_index[3:0] == 0 marks the first vector of gesture o_index[8:4]; consumers reset their accumulators on it.
- i_start while busy: ignored, not queued.
- Reset mid-stream: output goes dead immediately (o_valid = 0); no o_done is issued.

Test Plan:
- Fill and stream:
  - Stimulus: write vectors x=k, y=-k for k = 0..15, then pulse i_start; ROM returns x = addr[7:0], y = 1.
  - Required: o_valid high for 416 cycles starting 2 cycles after the start edge. o_index runs 0..415. o_vector_x = o_index[3:0]. o_lib_x = o_index[7:0]. o_done pulses once at cycle 418.
- Wrap order:
  - Stimulus: write 20 vectors with x = 0..19, then start.
  - Required: o_vector_x sequence is 4..19, repeated 26 times.
- Underfill:
  - Stimulus: write 15 vectors, start.
  - Required: o_busy stays 0 and no o_valid. After 1 more vector, start is accepted.
- Coincident events:
  - Stimulus: full window 0..15; i_start together with i_vec_valid (x = 99).
  - Required: stream shows 0..15. The next start shows 1..15, 99.
- Capture during stream:
  - Stimulus: write 10 vectors mid-stream and pulse i_start mid-stream.
  - Required: streamed data unchanged, second start ignored, window updated afterwards.
- Reset and clear:
  - Stimulus: assert i_rst_n low at o_index = 200.
  - Required: all outputs 0 asynchronously, o_busy = 0, no o_done.
  - Stimulus: i_clear after a full window, then start.
  - Required: start is ignored.
